multicycle_sequencer: RTL and testbench
=======================================

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Parameters
REQ-001 WORD_W, 8, datapath word width; carried for datapath consistency, no internal use.
REQ-002 OP_W, 4, opcode field width; SHALL be >= 4.
REQ-003 MAX_WAIT, 15, memory wait-state limit in cycles; SHALL be >= 1.

Interface
REQ-004 clock  in  1  single system clock, rising edge active.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 z_flag  in  1  accumulator-zero flag from datapath.
REQ-007 op  in  OP_W  opcode field of IR.
REQ-008 mem_ready  in  1  memory completion handshake, sampled while CS=1.
REQ-009 resume  in  1  leave HALT state.
REQ-010 ACC_bus, load_ACC, PC_bus, load_PC, load_IR, load_MAR, MDR_bus, load_MDR, ALU_ACC, ALU_add, ALU_sub, ALU_xor, INC_PC, Addr_bus, CS, R_NW  out  1 each  datapath/memory controls, same meaning as the current sequencer.
REQ-011 halted  out  1  sequencer is in HALT.
REQ-012 bus_error  out  1  sticky memory-timeout flag.

Function
REQ-013 Opcodes SHALL be: LOAD=0, STORE=1, ADD=2, SUB=3, XOR=4, BNE=5, BEQ=6, JMP=7, HALT=15; any other value SHALL execute as NOP.
REQ-014 States SHALL be: FETCH, IFETCH_MEM, DECODE, ADDR, ST_MDR, ST_MEM, OP_MEM, LD_ACC, ALU, BR_TAKE, HALT, ERROR.
REQ-015 Controls SHALL default to 0 in every state unless listed in REQ-016 through REQ-024.
REQ-016 FETCH: PC_bus, load_MAR, INC_PC, load_PC; SHALL go to IFETCH_MEM.
REQ-017 IFETCH_MEM: CS, R_NW held; SHALL go to DECODE on the cycle mem_ready=1 and SHALL stay otherwise.
REQ-018 DECODE: MDR_bus, load_IR; SHALL go to ADDR.
REQ-019 ADDR: Addr_bus, load_MAR. Transitions:
  - STORE -> ST_MDR
  - HALT -> HALT
  - JMP -> BR_TAKE
  - NOP -> FETCH
  - all others -> OP_MEM
REQ-020 ST_MDR: ACC_bus, load_MDR; SHALL go to ST_MEM.
REQ-021 ST_MEM: CS held with R_NW=0; SHALL go to FETCH on the cycle mem_ready=1.
REQ-022 OP_MEM: CS, R_NW held. On the cycle mem_ready=1:
  - LOAD -> LD_ACC
  - BNE with z_flag=0 -> BR_TAKE
  - BEQ with z_flag=1 -> BR_TAKE
  - untaken branch -> FETCH
  - ADD/SUB/XOR -> ALU
  - z_flag SHALL be sampled in that same cycle.
REQ-023 LD_ACC: MDR_bus, load_ACC, then FETCH. ALU: MDR_bus, ALU_ACC, load_ACC, plus exactly one of ALU_add/ALU_sub/ALU_xor per op, then FETCH.
REQ-024 BR_TAKE: MDR_bus, load_PC, then FETCH. JMP reaches BR_TAKE from ADDR with no memory read; MAR is loaded but unused.
REQ-025 Cycle counts with mem_ready=1 on its first sampled cycle:
  - NOP: 4 cycles
  - STORE, LOAD, ALU ops, taken branch: 6 cycles
  - untaken branch: 5 cycles
  - JMP: 5 cycles
  - each extra wait cycle adds 1.
REQ-026 A wait counter SHALL clear on entry to each CS state and increment every cycle CS=1 and mem_ready=0.
REQ-027 When the counter reaches MAX_WAIT with mem_ready=0, the next state SHALL be ERROR. mem_ready=1 in that same cycle SHALL take priority, and the normal transition occurs.
REQ-028 ERROR: all controls 0, bus_error=1. SHALL remain in ERROR until reset; resume SHALL be ignored.
REQ-029 HALT: halted=1, all controls 0. resume=1 SHALL go to FETCH next cycle; PC already points past HALT.
REQ-030 mem_ready SHALL be ignored in states where CS=0.
REQ-031 Outputs SHALL be purely combinational from state, op, z_flag and mem_ready, with no registered control outputs.

Reset
REQ-032 reset=1 SHALL force state FETCH and wait counter 0 immediately, without a clock edge.
REQ-033 During reset, all controls, halted and bus_error SHALL be 0.
REQ-034 reset asserted mid-instruction (including during a CS wait) SHALL abort it; no partial-state resume.
REQ-035 The first FETCH controls SHALL appear in the first cycle after reset deasserts.

Verification
REQ-036 Reset, then op=LOAD, mem_ready=1 always -> state sequence FETCH, IFETCH_MEM, DECODE, ADDR, OP_MEM, LD_ACC, FETCH; load_ACC high in exactly cycle 6.
REQ-037 op=STORE, mem_ready low for 3 cycles in ST_MEM -> CS=1 and R_NW=0 held for 4 cycles; instruction takes 9 cycles; load_MDR pulses once.
REQ-038 op=BNE with z_flag=0 and then z_flag=1; op=BEQ with z_flag=1 -> load_PC in BR_TAKE for BNE/z=0 (6 cycles) and BEQ/z=1; BNE/z=1 returns to FETCH after 5 cycles with no BR_TAKE load_PC.
REQ-039 MAX_WAIT=15, mem_ready held 0 in IFETCH_MEM -> ERROR entered after 15 wait cycles; bus_error=1 sticky; resume=1 has no effect; reset clears it.
REQ-040 op=HALT -> halted=1 after 4 cycles and held for 10 cycles; resume pulse -> FETCH next cycle with PC_bus=1.
REQ-041 Reset asserted asynchronously mid-ALU and mid-wait -> outputs zero before the next edge; restart at FETCH.

Source files
------------

// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if
//   Groups the sequencer's datapath/memory handshake signals.
//   master : the sequencer (drives controls, reads flags/op/handshakes)
//   slave  : the datapath/memory side (drives flags/op/handshakes)
//   Inputs to sequencer : z_flag, op[OP_W], mem_ready, resume
//   Outputs             : datapath/memory controls, halted, bus_error
interface multicycle_sequencer_if #(parameter int OP_W = 4);
    logic            z_flag;
    logic [OP_W-1:0] op;
    logic            mem_ready;
    logic            resume;

    logic ACC_bus, load_ACC, PC_bus, load_PC, load_IR, load_MAR;
    logic MDR_bus, load_MDR, ALU_ACC, ALU_add, ALU_sub, ALU_xor;
    logic INC_PC, Addr_bus, CS, R_NW;
    logic halted, bus_error;

    modport master (
        input  z_flag, op, mem_ready, resume,
        output ACC_bus, load_ACC, PC_bus, load_PC, load_IR, load_MAR,
               MDR_bus, load_MDR, ALU_ACC, ALU_add, ALU_sub, ALU_xor,
               INC_PC, Addr_bus, CS, R_NW, halted, bus_error
    );

    modport slave (
        output z_flag, op, mem_ready, resume,
        input  ACC_bus, load_ACC, PC_bus, load_PC, load_IR, load_MAR,
               MDR_bus, load_MDR, ALU_ACC, ALU_add, ALU_sub, ALU_xor,
               INC_PC, Addr_bus, CS, R_NW, halted, bus_error
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Control sequencer for a small accumulator machine. Steps each
//   instruction through fetch, decode, address and execute states and
//   waits on mem_ready in the memory (CS=1) states, with a wait-state
//   limit that parks the machine in a sticky ERROR state.
//   Ports:
//     clock : rising-edge system clock
//     reset : asynchronous active-high reset
//     bus   : multicycle_sequencer_if.master (flags, opcode, handshakes
//             in; datapath/memory controls, halted, bus_error out)
//   All outputs are decoded combinationally from the current state, op,
//   z_flag and mem_ready; only state and the wait counter are flops.
module multicycle_sequencer #(
    parameter int WORD_W   = 8,
    parameter int OP_W     = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic                     clock,
    input  logic                     reset,
    multicycle_sequencer_if.master   bus
);

    if (OP_W < 4)     begin : g_bad_op_w   $error("OP_W must be >= 4");     end
    if (MAX_WAIT < 1) begin : g_bad_wait   $error("MAX_WAIT must be >= 1"); end
    if (WORD_W < 1)   begin : g_bad_word_w $error("WORD_W must be >= 1");   end

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    // The counter reaches MAX_WAIT on the edge that leaves the
    // MAX_WAIT-th wait cycle, so that is the cycle that diverts to ERROR.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_JMP   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(15);

    typedef enum logic [3:0] {
        S_FETCH, S_IFETCH_MEM, S_DECODE, S_ADDR, S_ST_MDR, S_ST_MEM,
        S_OP_MEM, S_LD_ACC, S_ALU, S_BR_TAKE, S_HALT, S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic cs_state;
    assign cs_state = (state_q == S_IFETCH_MEM) || (state_q == S_ST_MEM) ||
                      (state_q == S_OP_MEM);

    // Next state and wait counter. The counter is zero in every non-CS
    // state and only leaves a CS state with mem_ready=1, so every CS
    // state is entered with a cleared counter.
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        if (cs_state && !bus.mem_ready) begin
            wait_d = wait_q + 1'b1;
            if (wait_q == WAIT_LAST) state_d = S_ERROR;
        end
        case (state_q)
            S_FETCH:      state_d = S_IFETCH_MEM;
            S_IFETCH_MEM: if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE:     state_d = S_ADDR;
            S_ADDR: begin
                case (bus.op)
                    OP_STORE: state_d = S_ST_MDR;
                    OP_HALT:  state_d = S_HALT;
                    OP_JMP:   state_d = S_BR_TAKE;
                    OP_LOAD, OP_ADD, OP_SUB, OP_XOR, OP_BNE, OP_BEQ:
                              state_d = S_OP_MEM;
                    default:  state_d = S_FETCH;  // NOP
                endcase
            end
            S_ST_MDR:     state_d = S_ST_MEM;
            S_ST_MEM:     if (bus.mem_ready) state_d = S_FETCH;
            S_OP_MEM: begin
                if (bus.mem_ready) begin
                    case (bus.op)
                        OP_LOAD:                 state_d = S_LD_ACC;
                        OP_BNE:                  state_d = bus.z_flag ? S_FETCH : S_BR_TAKE;
                        OP_BEQ:                  state_d = bus.z_flag ? S_BR_TAKE : S_FETCH;
                        OP_ADD, OP_SUB, OP_XOR:  state_d = S_ALU;
                        default:                 state_d = S_FETCH;
                    endcase
                end
            end
            S_LD_ACC, S_ALU, S_BR_TAKE: state_d = S_FETCH;
            S_HALT:       if (bus.resume) state_d = S_FETCH;
            S_ERROR:      state_d = S_ERROR;
            default:      state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Control decode. Gated by reset so that the FETCH controls of the
    // reset state do not leak out while reset is held.
    always_comb begin
        bus.ACC_bus   = 1'b0; bus.load_ACC = 1'b0; bus.PC_bus   = 1'b0;
        bus.load_PC   = 1'b0; bus.load_IR  = 1'b0; bus.load_MAR = 1'b0;
        bus.MDR_bus   = 1'b0; bus.load_MDR = 1'b0; bus.ALU_ACC  = 1'b0;
        bus.ALU_add   = 1'b0; bus.ALU_sub  = 1'b0; bus.ALU_xor  = 1'b0;
        bus.INC_PC    = 1'b0; bus.Addr_bus = 1'b0; bus.CS       = 1'b0;
        bus.R_NW      = 1'b0; bus.halted   = 1'b0; bus.bus_error = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    bus.PC_bus = 1'b1; bus.load_MAR = 1'b1;
                    bus.INC_PC = 1'b1; bus.load_PC  = 1'b1;
                end
                S_IFETCH_MEM, S_OP_MEM: begin
                    bus.CS = 1'b1; bus.R_NW = 1'b1;
                end
                S_DECODE:  begin bus.MDR_bus = 1'b1;  bus.load_IR  = 1'b1; end
                S_ADDR:    begin bus.Addr_bus = 1'b1; bus.load_MAR = 1'b1; end
                S_ST_MDR:  begin bus.ACC_bus = 1'b1;  bus.load_MDR = 1'b1; end
                S_ST_MEM:  bus.CS = 1'b1;
                S_LD_ACC:  begin bus.MDR_bus = 1'b1;  bus.load_ACC = 1'b1; end
                S_ALU: begin
                    bus.MDR_bus = 1'b1; bus.ALU_ACC = 1'b1; bus.load_ACC = 1'b1;
                    case (bus.op)
                        OP_ADD:  bus.ALU_add = 1'b1;
                        OP_SUB:  bus.ALU_sub = 1'b1;
                        OP_XOR:  bus.ALU_xor = 1'b1;
                        default: ;
                    endcase
                end
                S_BR_TAKE: begin bus.MDR_bus = 1'b1; bus.load_PC = 1'b1; end
                S_HALT:    bus.halted    = 1'b1;
                S_ERROR:   bus.bus_error = 1'b1;
                default:   ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;
    logic clock;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    multicycle_sequencer_if #(.OP_W(4)) bus_if ();

    multicycle_sequencer #(.WORD_W(8), .OP_W(4), .MAX_WAIT(15)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Control vector, MSB first.
    localparam logic [17:0] ACC_BUS = 18'h1 << 17, LOAD_ACC = 18'h1 << 16,
        PC_BUS  = 18'h1 << 15, LOAD_PC = 18'h1 << 14, LOAD_IR  = 18'h1 << 13,
        LOAD_MAR = 18'h1 << 12, MDR_BUS = 18'h1 << 11, LOAD_MDR = 18'h1 << 10,
        ALU_ACC = 18'h1 << 9, ALU_ADD = 18'h1 << 8, ALU_SUB = 18'h1 << 7,
        ALU_XOR = 18'h1 << 6, INC_PC = 18'h1 << 5, ADDR_BUS = 18'h1 << 4,
        CS = 18'h1 << 3, R_NW = 18'h1 << 2, HALTED = 18'h1 << 1, BUS_ERR = 18'h1;

    localparam logic [17:0] V_ZERO  = '0;
    localparam logic [17:0] V_FETCH = PC_BUS | LOAD_MAR | INC_PC | LOAD_PC;
    localparam logic [17:0] V_IMEM  = CS | R_NW;
    localparam logic [17:0] V_DEC   = MDR_BUS | LOAD_IR;
    localparam logic [17:0] V_ADDR  = ADDR_BUS | LOAD_MAR;
    localparam logic [17:0] V_STMDR = ACC_BUS | LOAD_MDR;
    localparam logic [17:0] V_STMEM = CS;
    localparam logic [17:0] V_OPMEM = CS | R_NW;
    localparam logic [17:0] V_LDACC = MDR_BUS | LOAD_ACC;
    localparam logic [17:0] V_ALU   = MDR_BUS | ALU_ACC | LOAD_ACC;
    localparam logic [17:0] V_BR    = MDR_BUS | LOAD_PC;
    localparam logic [17:0] V_HALT  = HALTED;
    localparam logic [17:0] V_ERR   = BUS_ERR;

    localparam logic [3:0] OP_LOAD = 4'd0, OP_STORE = 4'd1, OP_ADD = 4'd2,
        OP_SUB = 4'd3, OP_XOR = 4'd4, OP_BNE = 4'd5, OP_BEQ = 4'd6,
        OP_JMP = 4'd7, OP_NOP = 4'd9, OP_HALT = 4'd15;

    logic [17:0] ctl;
    assign ctl = {bus_if.ACC_bus, bus_if.load_ACC, bus_if.PC_bus, bus_if.load_PC,
                  bus_if.load_IR, bus_if.load_MAR, bus_if.MDR_bus, bus_if.load_MDR,
                  bus_if.ALU_ACC, bus_if.ALU_add, bus_if.ALU_sub, bus_if.ALU_xor,
                  bus_if.INC_PC, bus_if.Addr_bus, bus_if.CS, bus_if.R_NW,
                  bus_if.halted, bus_if.bus_error};

    task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive mem_ready, check mid-cycle, end #1 after the edge.
    task automatic cyc(input string tag, input logic [17:0] exp, input logic mr);
        bus_if.mem_ready = mr;
        @(negedge clock);
        chk(tag, ctl, exp);
        @(posedge clock);
        #1;
    endtask

    // FETCH, IFETCH_MEM, DECODE, ADDR with immediate memory completion.
    task automatic front(input string tag, input logic [3:0] op, input logic z);
        bus_if.op = op;
        bus_if.z_flag = z;
        cyc({tag, ".fetch"}, V_FETCH, 1'b0);  // mem_ready ignored with CS=0
        cyc({tag, ".imem"},  V_IMEM,  1'b1);
        cyc({tag, ".dec"},   V_DEC,   1'b0);
        cyc({tag, ".addr"},  V_ADDR,  1'b0);
    endtask

    // Assert reset between edges, check outputs drop, release after an edge.
    task automatic async_reset(input string tag);
        #1 reset = 1'b1;
        #1 chk({tag, ".rst_zero"}, ctl, V_ZERO);
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus_if.op = OP_NOP;
        bus_if.z_flag = 1'b0;
        bus_if.mem_ready = 1'b1;
        bus_if.resume = 1'b0;
        @(negedge clock);
        chk("reset", ctl, V_ZERO);
        @(posedge clock);
        #1 reset = 1'b0;

        // LOAD: load_ACC only in cycle 6
        front("load", OP_LOAD, 1'b0);
        cyc("load.opmem", V_OPMEM, 1'b1);
        cyc("load.ldacc", V_LDACC, 1'b1);

        // STORE with 3 wait cycles: 9 cycles total
        front("store", OP_STORE, 1'b0);
        cyc("store.stmdr", V_STMDR, 1'b0);
        for (int i = 0; i < 3; i++) cyc("store.wait", V_STMEM, 1'b0);
        cyc("store.stmem", V_STMEM, 1'b1);

        // branches
        front("bne0", OP_BNE, 1'b0);
        cyc("bne0.opmem", V_OPMEM, 1'b1);
        cyc("bne0.br",    V_BR,    1'b1);
        front("bne1", OP_BNE, 1'b1);
        cyc("bne1.opmem", V_OPMEM, 1'b1);
        front("beq1", OP_BEQ, 1'b1);          // bne1 fell straight to FETCH
        cyc("beq1.opmem", V_OPMEM, 1'b1);
        cyc("beq1.br",    V_BR,    1'b1);
        front("beq0", OP_BEQ, 1'b0);
        cyc("beq0.opmem", V_OPMEM, 1'b1);

        // ALU ops
        front("add", OP_ADD, 1'b0);
        cyc("add.opmem", V_OPMEM, 1'b1);
        cyc("add.alu",   V_ALU | ALU_ADD, 1'b1);
        front("sub", OP_SUB, 1'b0);
        cyc("sub.opmem", V_OPMEM, 1'b1);
        cyc("sub.alu",   V_ALU | ALU_SUB, 1'b1);
        front("xor", OP_XOR, 1'b0);
        cyc("xor.opmem", V_OPMEM, 1'b1);
        cyc("xor.alu",   V_ALU | ALU_XOR, 1'b1);

        // NOP (4 cycles), JMP (5 cycles)
        front("nop", OP_NOP, 1'b0);
        front("jmp", OP_JMP, 1'b0);
        cyc("jmp.br", V_BR, 1'b0);

        // HALT held 10 cycles, then resume
        front("halt", OP_HALT, 1'b0);
        for (int i = 0; i < 10; i++) cyc("halt.hold", V_HALT, 1'b1);
        bus_if.resume = 1'b1;
        cyc("halt.resume", V_HALT, 1'b1);
        bus_if.resume = 1'b0;

        // Wait limit boundary: ready on the 15th wait cycle wins
        bus_if.op = OP_NOP;
        cyc("lim.fetch", V_FETCH, 1'b1);     // also the post-resume FETCH
        for (int i = 0; i < 14; i++) cyc("lim.wait", V_IMEM, 1'b0);
        cyc("lim.ready", V_IMEM, 1'b1);
        cyc("lim.dec",   V_DEC,  1'b0);
        cyc("lim.addr",  V_ADDR, 1'b0);

        // Timeout: 15 wait cycles then sticky ERROR, resume ignored
        cyc("to.fetch", V_FETCH, 1'b0);
        for (int i = 0; i < 15; i++) cyc("to.wait", V_IMEM, 1'b0);
        bus_if.resume = 1'b1;
        for (int i = 0; i < 3; i++) cyc("to.error", V_ERR, 1'b1);
        bus_if.resume = 1'b0;
        async_reset("to");
        cyc("to.after", V_FETCH, 1'b0);

        // Async reset mid-ALU
        bus_if.op = OP_ADD;
        cyc("mid_alu.imem",  V_IMEM,  1'b1);
        cyc("mid_alu.dec",   V_DEC,   1'b1);
        cyc("mid_alu.addr",  V_ADDR,  1'b1);
        cyc("mid_alu.opmem", V_OPMEM, 1'b1);
        @(negedge clock);
        chk("mid_alu.alu", ctl, V_ALU | ALU_ADD);
        async_reset("mid_alu");

        // Async reset mid-wait in ST_MEM
        front("mid_wait", OP_STORE, 1'b0);
        cyc("mid_wait.stmdr", V_STMDR, 1'b0);
        cyc("mid_wait.w0", V_STMEM, 1'b0);
        cyc("mid_wait.w1", V_STMEM, 1'b0);
        bus_if.mem_ready = 1'b0;
        @(negedge clock);
        chk("mid_wait.w2", ctl, V_STMEM);
        async_reset("mid_wait");
        cyc("mid_wait.restart", V_FETCH, 1'b0);
        cyc("mid_wait.imem",    V_IMEM,  1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
